// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code receiver.
//   ps2_state_e  - frame FSM states
//   PS2_EXT/BRK  - prefix bytes folded into event flags
//   ps2_event_t  - 10-bit queued event {ext, brk, code}
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word fall-through event queue.
//   clk, rst  - clock, synchronous active-high reset
//   push      - write wr_data (accepted when not full, or when a pop frees a slot)
//   wr_data   - entry to write
//   pop       - remove head entry (ignored when empty)
//   rd_data   - head entry, valid whenever empty=0
//   empty     - no entries stored
//   full      - DEPTH entries stored
module ps2_event_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty;
      // A simultaneous pop frees the slot this push needs.
      do_push  = push & (~full | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver producing make/break key events.
//   clk, rst     - system clock, synchronous active-high reset
//   ps2_clk      - asynchronous PS/2 clock pin
//   ps2_data     - asynchronous PS/2 data pin
//   rd_en        - pop the head event (ignored when valid=0)
//   code         - head event scan code
//   extended     - head event was preceded by E0
//   key_release  - head event was preceded by F0 (break)
//   valid        - event queue non-empty
//   frame_err    - one-cycle pulse on parity, stop-bit or timeout error
//   overflow     - sticky, an event was dropped on a full queue
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd_en,
   output logic [7:0] code,
   output logic       extended,
   output logic       key_release,
   output logic       valid,
   output logic       frame_err,
   output logic       overflow
);

   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   s_clk, s_data;

   logic                   filt_q, filt_d;
   logic                   filt_prev_q, filt_prev_d;
   logic [FLT_W-1:0]       filt_cnt_q, filt_cnt_d;
   logic                   fall;

   ps2_state_e             state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   par_q, par_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic                   ext_q, ext_d;
   logic                   brk_q, brk_d;
   logic                   ferr_q, ferr_d;
   logic                   overflow_q, overflow_d;
   logic                   err;
   logic                   byte_ok;

   logic                   fifo_push;
   ps2_event_t             fifo_wr;
   ps2_event_t             head;
   logic [9:0]             fifo_rd_data;
   logic                   fifo_empty;
   logic                   fifo_full;

   assign s_clk  = clk_sync_q[SYNC_STAGES-1];
   assign s_data = data_sync_q[SYNC_STAGES-1];

   // Synchroniser and glitch filter: the filtered clock follows s_clk only
   // after FILTER_LEN consecutive samples disagreeing with it.
   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      filt_d      = filt_q;
      filt_cnt_d  = '0;
      if (s_clk != filt_q) begin
         if (filt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
            filt_d = s_clk;
         end else begin
            filt_cnt_d = filt_cnt_q + FLT_W'(1);
         end
      end
      filt_prev_d = filt_q;
   end

   assign fall = filt_prev_q & ~filt_q;

   // Frame FSM, timeout counter and prefix folding.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      ext_d     = ext_q;
      brk_d     = brk_q;
      err       = 1'b0;
      byte_ok   = 1'b0;
      fifo_push = 1'b0;
      fifo_wr   = '{ext: ext_q, brk: brk_q, code: shift_q};

      if (state_q == IDLE || fall) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (fall && !s_data) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_d   = {s_data, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (fall) begin
               par_d   = s_data;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               if ((^{shift_q, par_q}) && s_data) begin
                  byte_ok = 1'b1;
               end else begin
                  err = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // An edge arriving on the expiry cycle keeps the frame alive.
      if (state_q != IDLE && !fall && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
         err     = 1'b1;
         state_d = IDLE;
         tmo_d   = '0;
      end

      if (err) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (byte_ok) begin
         if (shift_q == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (shift_q == PS2_BRK) begin
            brk_d = 1'b1;
         end else begin
            fifo_push = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
         end
      end

      ferr_d     = err;
      overflow_d = overflow_q | (fifo_push & fifo_full & ~(rd_en & ~fifo_empty));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         filt_cnt_q  <= '0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         tmo_q       <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         ferr_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_prev_d;
         filt_cnt_q  <= filt_cnt_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         tmo_q       <= tmo_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         ferr_q      <= ferr_d;
         overflow_q  <= overflow_d;
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (10)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .wr_data (fifo_wr),
      .pop     (rd_en),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign head        = fifo_rd_data;
   assign code        = head.code;
   assign extended    = head.ext;
   assign key_release = head.brk;
   assign valid       = ~fifo_empty;
   assign frame_err   = ferr_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed bench for ps2_scancode_rx with a short timeout
// and a 4-entry queue so overflow and timeout cases run quickly.
module tb_ps2_scancode_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rd_en;
   logic [7:0] code;
   logic       extended;
   logic       key_release;
   logic       valid;
   logic       frame_err;
   logic       overflow;

   int n_vec     = 0;
   int n_err     = 0;
   int ferr_cnt  = 0;
   int ferr_wide = 0;
   logic ferr_prev = 1'b0;

   always #5 clk = ~clk;

   ps2_scancode_rx #(
      .SYNC_STAGES    (2),
      .FILTER_LEN     (4),
      .TIMEOUT_CYCLES (200),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rd_en       (rd_en),
      .code        (code),
      .extended    (extended),
      .key_release (key_release),
      .valid       (valid),
      .frame_err   (frame_err),
      .overflow    (overflow)
   );

   always @(negedge clk) begin
      if (frame_err) ferr_cnt++;
      if (frame_err && ferr_prev) ferr_wide++;
      ferr_prev = frame_err;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One PS/2 bit: clock high 16 cycles, low 20 cycles; optional short glitches.
   task automatic ps2_bit(input logic v, input bit g);
      ps2_data = v;
      ps2_clk  = 1'b1;
      if (g) begin
         cycles(10); ps2_clk = 1'b0; cycles(2); ps2_clk = 1'b1; cycles(4);
      end else begin
         cycles(16);
      end
      ps2_clk = 1'b0;
      if (g) begin
         cycles(10); ps2_clk = 1'b1; cycles(1); ps2_clk = 1'b0; cycles(9);
      end else begin
         cycles(20);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop, input bit g);
      logic par;
      par = (~^b) ^ bad_par;
      ps2_bit(1'b0, g);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], g);
      ps2_bit(par, g);
      ps2_bit(stop, g);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      cycles(30);
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic partial_frame(input logic [7:0] b, input int nbits);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      cycles(1);
      rd_en = 1'b0;
   endtask

   task automatic check_head(input string tag, input logic [7:0] c, input logic e, input logic r);
      check({tag, ".valid"}, 32'(valid), 32'd1);
      check({tag, ".code"}, 32'(code), 32'(c));
      check({tag, ".ext"}, 32'(extended), 32'(e));
      check({tag, ".rel"}, 32'(key_release), 32'(r));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".valid"}, 32'(valid), 32'd0);
      check({tag, ".code"}, 32'(code), 32'h00);
      check({tag, ".ext"}, 32'(extended), 32'd0);
      check({tag, ".rel"}, 32'(key_release), 32'd0);
      check({tag, ".ferr"}, 32'(frame_err), 32'd0);
      check({tag, ".ovf"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      int f0;
      bit found;
      logic [7:0] exp_code;

      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
      cycles(5);
      rst = 1'b0;
      cycles(1);
      check_reset_outputs("reset");

      // Plain make code, then pop.
      send_good(8'h1C);
      check_head("make1c", 8'h1C, 1'b0, 1'b0);
      pop();
      check("make1c.popped", 32'(valid), 32'd0);

      // Extended break: E0 F0 75 folds into one event; flags clear afterwards.
      send_good(8'hE0);
      send_good(8'hF0);
      send_good(8'h75);
      check_head("e0f075", 8'h75, 1'b1, 1'b1);
      pop();
      check("e0f075.single", 32'(valid), 32'd0);
      send_good(8'h1C);
      check_head("after_prefix", 8'h1C, 1'b0, 1'b0);
      pop();

      // Bad parity, then good frame.
      f0 = ferr_cnt;
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      check("badpar.noevt", 32'(valid), 32'd0);
      send_good(8'h1C);
      check("badpar.ferr", 32'(ferr_cnt - f0), 32'd1);
      check_head("badpar.next", 8'h1C, 1'b0, 1'b0);
      pop();
      check("badpar.only", 32'(valid), 32'd0);

      // Bad stop bit, then good frame.
      f0 = ferr_cnt;
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      check("badstop.noevt", 32'(valid), 32'd0);
      send_good(8'h1C);
      check("badstop.ferr", 32'(ferr_cnt - f0), 32'd1);
      check_head("badstop.next", 8'h1C, 1'b0, 1'b0);
      pop();
      check("badstop.only", 32'(valid), 32'd0);

      // Timeout after F0 and four data bits; break flag must be cleared.
      f0 = ferr_cnt;
      send_good(8'hF0);
      partial_frame(8'h2B, 4);
      cycles(300);
      check("timeout.ferr", 32'(ferr_cnt - f0), 32'd1);
      check("timeout.noevt", 32'(valid), 32'd0);
      send_good(8'h2B);
      check_head("timeout.next", 8'h2B, 1'b0, 1'b0);
      pop();

      // Overflow: five pushes into a 4-deep queue.
      for (int k = 0; k < 5; k++) send_good(8'(8'h11 * (k + 1)));
      check("ovf.set", 32'(overflow), 32'd1);
      for (int k = 0; k < 4; k++) begin
         exp_code = 8'(8'h11 * (k + 1));
         check($sformatf("ovf.rd%0d", k), 32'(code), 32'(exp_code));
         pop();
      end
      check("ovf.drained", 32'(valid), 32'd0);

      // Push with pop on a full queue: no drop, order preserved.
      rst = 1'b1; cycles(2); rst = 1'b0; cycles(1);
      check("ovf.cleared", 32'(overflow), 32'd0);
      for (int k = 1; k <= 4; k++) send_good(8'(8'h60 + k));
      found = 1'b0;
      fork
         send_good(8'h65);
         begin
            for (int t = 0; t < 2000 && !found; t++) begin
               @(negedge clk);
               if (dut.fifo_push) begin
                  rd_en = 1'b1;
                  @(negedge clk);
                  rd_en = 1'b0;
                  found = 1'b1;
               end
            end
         end
      join
      check("fullpop.seen", 32'(found), 32'd1);
      check("fullpop.noovf", 32'(overflow), 32'd0);
      for (int k = 2; k <= 5; k++) begin
         exp_code = 8'(8'h60 + k);
         check($sformatf("fullpop.rd%0d", k), 32'(code), 32'(exp_code));
         pop();
      end
      check("fullpop.drained", 32'(valid), 32'd0);

      // Short clock glitches must not disturb reception.
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
      check_head("glitch", 8'h3C, 1'b0, 1'b0);
      check("glitch.noferr", 32'(ferr_cnt - f0), 32'd0);
      pop();

      // Reset mid-frame with an event queued.
      send_good(8'h1C);
      f0 = ferr_cnt;
      partial_frame(8'hA5, 3);
      rst = 1'b1; cycles(3); rst = 1'b0; cycles(1);
      check_reset_outputs("midrst");
      cycles(20);
      check("midrst.noferr", 32'(ferr_cnt - f0), 32'd0);
      send_good(8'hA5);
      check_head("midrst.next", 8'hA5, 1'b0, 1'b0);
      pop();

      check("ferr.width", 32'(ferr_wide), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
